// File: rtl/charbuf_pkg.sv
// charbuf_pkg: shared types and helpers for the charbuf_n character buffer.
package charbuf_pkg;

    typedef enum logic {
        OVF_DROP_OLDEST = 1'b0,
        OVF_REJECT      = 1'b1
    } ovf_mode_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_RECALL,
        OP_BKSP,
        OP_INS
    } op_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/charbuf_n_if.sv
// charbuf_n_if: keypad-side controls and buffer outputs of charbuf_n.
interface charbuf_n_if #(
    parameter int CHAR_W = 4,
    parameter int DEPTH  = 8
) ();
    import charbuf_pkg::*;

    localparam int CW = count_w(DEPTH);

    logic                     enable;
    logic                     clr;
    logic                     bksp;
    logic                     is_ctrl;
    logic                     recall;
    logic [CHAR_W-1:0]        in_char;
    logic [CHAR_W*DEPTH-1:0]  out;
    logic [CW-1:0]            count;
    logic                     is_empty;
    logic                     is_full;
    logic                     ovf;

    modport master (
        output enable, clr, bksp, is_ctrl, recall, in_char,
        input  out, count, is_empty, is_full, ovf
    );

    modport slave (
        input  enable, clr, bksp, is_ctrl, recall, in_char,
        output out, count, is_empty, is_full, ovf
    );

endinterface

// File: rtl/charbuf_snap.sv
// charbuf_snap: holds the pre-clear buffer contents for recall.
module charbuf_snap #(
    parameter int W  = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap,
    input  logic [W-1:0]  d_out,
    input  logic [CW-1:0] d_count,
    output logic [W-1:0]  q_out,
    output logic [CW-1:0] q_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_out   <= '0;
            q_count <= '0;
        end else if (cap) begin
            q_out   <= d_out;
            q_count <= d_count;
        end
    end

endmodule

// File: rtl/charbuf_n.sv
// charbuf_n: parametrised left-shifting character line buffer with occupancy count.
// Define CHARBUF_RECALL_EN to add the clear/recall snapshot (charbuf_snap).
module charbuf_n
    import charbuf_pkg::*;
#(
    parameter int        CHAR_W   = 4,
    parameter int        DEPTH    = 8,
    parameter ovf_mode_t OVF_MODE = OVF_DROP_OLDEST
) (
    input  logic       clk,
    input  logic       rst,
    charbuf_n_if.slave bus
);

    localparam int W  = CHAR_W * DEPTH;
    localparam int CW = count_w(DEPTH);

    logic [W-1:0]  out_q;
    logic [W-1:0]  snap_out;
    logic [CW-1:0] count_q;
    logic [CW-1:0] snap_count;
    logic          ovf_q;
    logic          do_recall;
    logic          full;
    op_t           op;

`ifdef CHARBUF_RECALL_EN
    charbuf_snap #(.W(W), .CW(CW)) u_snap (
        .clk     (clk),
        .rst     (rst),
        .cap     (op == OP_CLR),
        .d_out   (out_q),
        .d_count (count_q),
        .q_out   (snap_out),
        .q_count (snap_count)
    );
    assign do_recall = bus.recall;
`else
    assign snap_out   = '0;
    assign snap_count = '0;
    assign do_recall  = 1'b0;
`endif

    assign full = count_q == CW'(DEPTH);

    always_comb
        op = bus.clr                       ? OP_CLR    :
             do_recall                     ? OP_RECALL :
             (bus.enable && bus.bksp)      ? OP_BKSP   :
             (bus.enable && !bus.is_ctrl)  ? OP_INS    : OP_HOLD;

    // bksp on an empty buffer still wins over insert but changes nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= (op == OP_INS) && full;
            case (op)
                OP_CLR: begin
                    out_q   <= '0;
                    count_q <= '0;
                end
                OP_RECALL: begin
                    out_q   <= snap_out;
                    count_q <= snap_count;
                end
                OP_BKSP: if (count_q != '0) begin
                    out_q   <= {{CHAR_W{1'b0}}, out_q[W-1:CHAR_W]};
                    count_q <= count_q - 1'b1;
                end
                OP_INS: if (!(full && OVF_MODE == OVF_REJECT)) begin
                    out_q <= {out_q[W-CHAR_W-1:0], bus.in_char};
                    if (!full) count_q <= count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.count    = count_q;
    assign bus.is_empty = count_q == '0;
    assign bus.is_full  = full;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_charbuf_n.sv
// tb_charbuf_n: drives one drop-oldest and one reject instance with identical
// stimulus and compares both against queue-based reference models.
module tb_charbuf_n;
    import charbuf_pkg::*;

    logic       clk = 0;
    logic       rst = 0, enable = 0, clr = 0, bksp = 0, is_ctrl = 0, recall = 0;
    logic [3:0] in_char = 0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    charbuf_n_if #(.CHAR_W(4), .DEPTH(8)) b0 ();
    charbuf_n_if #(.CHAR_W(4), .DEPTH(8)) b1 ();

    assign b0.enable = enable;  assign b1.enable = enable;
    assign b0.clr = clr;        assign b1.clr = clr;
    assign b0.bksp = bksp;      assign b1.bksp = bksp;
    assign b0.is_ctrl = is_ctrl; assign b1.is_ctrl = is_ctrl;
    assign b0.recall = recall;  assign b1.recall = recall;
    assign b0.in_char = in_char; assign b1.in_char = in_char;

    charbuf_n #(.CHAR_W(4), .DEPTH(8), .OVF_MODE(OVF_DROP_OLDEST)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    charbuf_n #(.CHAR_W(4), .DEPTH(8), .OVF_MODE(OVF_REJECT))      dut1 (.clk(clk), .rst(rst), .bus(b1));

`ifdef CHARBUF_RECALL_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    // Reference: each buffer is a queue of characters, oldest first.
    int   q0[$], q1[$], s0[$], s1[$];
    logic e_ovf0 = 0, e_ovf1 = 0;

    function automatic logic [31:0] pack(input int q[$]);
        logic [31:0] r = '0;
        for (int i = 0; i < q.size(); i++) r[4*i +: 4] = 4'(q[q.size()-1-i]);
        return r;
    endfunction

    task automatic tick;
        if (rst) begin
            q0.delete(); q1.delete(); s0.delete(); s1.delete();
            e_ovf0 = 0; e_ovf1 = 0;
        end else begin
            e_ovf0 = 0; e_ovf1 = 0;
            if (clr) begin
                s0 = q0; s1 = q1; q0.delete(); q1.delete();
            end else if (REC && recall) begin
                q0 = s0; q1 = s1;
            end else if (enable && bksp) begin
                if (q0.size() > 0) void'(q0.pop_back());
                if (q1.size() > 0) void'(q1.pop_back());
            end else if (enable && !is_ctrl) begin
                if (q0.size() == 8) begin void'(q0.pop_front()); e_ovf0 = 1; end
                q0.push_back(int'(in_char));
                if (q1.size() == 8) e_ovf1 = 1; else q1.push_back(int'(in_char));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle;
        rst = 0; enable = 0; clr = 0; bksp = 0; is_ctrl = 0; recall = 0;
    endtask

    task automatic ins(input int v);
        enable = 1; in_char = 4'(v); tick(); enable = 0;
    endtask

    task automatic test_reset;
        rst = 1; tick(); idle();
        checks++;
        if ({b0.out, b0.count, b0.is_empty, b0.is_full, b0.ovf} !== {32'h0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset: out=%h count=%0d empty=%b full=%b ovf=%b want 0/0/1/0/0",
                               b0.out, b0.count, b0.is_empty, b0.is_full, b0.ovf);
        end
        in_char = 4'd5; tick();
        checks++;
        if (b0.out !== 32'h0 || b0.count !== 4'd0) begin
            errors++; $display("FAIL idle_hold: out=%h count=%0d want 0/0", b0.out, b0.count);
        end
    endtask

    task automatic test_zero_char;
        ins(0);
        checks++;
        if (b0.out !== 32'h0 || b0.count !== 4'd1 || b0.is_empty !== 1'b0) begin
            errors++; $display("FAIL zero_char: out=%h count=%0d empty=%b want 0/1/0", b0.out, b0.count, b0.is_empty);
        end
        clr = 1; tick(); idle();
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 8; i++) ins(i);
        checks++;
        if (b0.out !== 32'h12345678 || b0.is_full !== 1'b1 || b0.ovf !== 1'b0 || b1.out !== 32'h12345678) begin
            errors++; $display("FAIL fill: out0=%h full=%b ovf=%b out1=%h want 12345678/1/0", b0.out, b0.is_full, b0.ovf, b1.out);
        end
        ins(9);
        checks++;
        if (b0.out !== 32'h23456789 || b0.count !== 4'd8 || b0.ovf !== 1'b1) begin
            errors++; $display("FAIL drop_oldest: out=%h count=%0d ovf=%b want 23456789/8/1", b0.out, b0.count, b0.ovf);
        end
        checks++;
        if (b1.out !== 32'h12345678 || b1.count !== 4'd8 || b1.ovf !== 1'b1) begin
            errors++; $display("FAIL reject: out=%h count=%0d ovf=%b want 12345678/8/1", b1.out, b1.count, b1.ovf);
        end
        tick();
        checks++;
        if (b0.ovf !== 1'b0 || b1.ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_pulse: ovf0=%b ovf1=%b want 0/0", b0.ovf, b1.ovf);
        end
        clr = 1; tick(); idle();
    endtask

    task automatic test_bksp;
        for (int i = 1; i <= 8; i++) ins(i);
        enable = 1; bksp = 1; in_char = 4'hA; tick();
        checks++;
        if (b0.out !== 32'h01234567 || b0.count !== 4'd7 || b1.out !== 32'h01234567) begin
            errors++; $display("FAIL bksp: out0=%h count=%0d out1=%h want 01234567/7", b0.out, b0.count, b1.out);
        end
        enable = 0; tick();
        checks++;
        if (b0.out !== 32'h01234567 || b0.count !== 4'd7) begin
            errors++; $display("FAIL bksp_gated: out=%h count=%0d want 01234567/7", b0.out, b0.count);
        end
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (b0.ovf !== 1'b0 || b0.count !== 4'(q0.size()) || b0.out !== pack(q0)) begin
                errors++; $display("FAIL bksp_drain%0d: out=%h count=%0d ovf=%b want %h/%0d/0",
                                   i, b0.out, b0.count, b0.ovf, pack(q0), q0.size());
            end
        end
        checks++;
        if (b0.out !== 32'h0 || b0.count !== 4'd0 || b0.is_empty !== 1'b1) begin
            errors++; $display("FAIL bksp_empty: out=%h count=%0d empty=%b want 0/0/1", b0.out, b0.count, b0.is_empty);
        end
        idle();
    endtask

    task automatic test_ctrl_clr_recall;
        for (int i = 1; i <= 3; i++) ins(i);
        is_ctrl = 1; enable = 1; in_char = 4'd5; tick(); idle();
        checks++;
        if (b0.out !== 32'h123 || b0.count !== 4'd3) begin
            errors++; $display("FAIL ctrl: out=%h count=%0d want 123/3", b0.out, b0.count);
        end
        clr = 1; tick(); idle();
        checks++;
        if (b0.out !== 32'h0 || b0.is_empty !== 1'b1 || b0.ovf !== 1'b0) begin
            errors++; $display("FAIL clr: out=%h empty=%b ovf=%b want 0/1/0", b0.out, b0.is_empty, b0.ovf);
        end
        for (int r = 0; r < 2; r++) begin
            recall = 1; tick(); idle();
            checks++;
            if (b0.out !== (REC ? 32'h123 : 32'h0) || b0.count !== (REC ? 4'd3 : 4'd0)) begin
                errors++; $display("FAIL recall%0d: out=%h count=%0d want %h/%0d",
                                   r, b0.out, b0.count, REC ? 32'h123 : 32'h0, REC ? 3 : 0);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            rst     = $urandom_range(0, 49) == 0;
            clr     = $urandom_range(0, 19) == 0;
            recall  = $urandom_range(0, 14) == 0;
            enable  = $urandom_range(0, 3) != 0;
            bksp    = $urandom_range(0, 3) == 0;
            is_ctrl = $urandom_range(0, 7) == 0;
            in_char = 4'($urandom);
            tick();
            checks++;
            if ({b0.out, b0.count, b0.is_empty, b0.is_full, b0.ovf} !==
                {pack(q0), 4'(q0.size()), q0.size() == 0, q0.size() == 8, e_ovf0}) begin
                errors++; $display("FAIL rand_drop%0d: out=%h count=%0d ovf=%b want %h/%0d/%b",
                                   n, b0.out, b0.count, b0.ovf, pack(q0), q0.size(), e_ovf0);
            end
            checks++;
            if ({b1.out, b1.count, b1.is_empty, b1.is_full, b1.ovf} !==
                {pack(q1), 4'(q1.size()), q1.size() == 0, q1.size() == 8, e_ovf1}) begin
                errors++; $display("FAIL rand_reject%0d: out=%h count=%0d ovf=%b want %h/%0d/%b",
                                   n, b1.out, b1.count, b1.ovf, pack(q1), q1.size(), e_ovf1);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_char();
        test_fill_overflow();
        test_bksp();
        test_ctrl_clr_recall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/charbuf_n.md
# charbuf_n

Parametrised successor to the fixed 8-character, 4-bit keypad character buffer. It holds up to DEPTH characters of CHAR_W bits as a left-shifting line buffer. Newest character is at the least-significant slot. It tracks an explicit occupancy count, so a zero-valued character counts as a character. It adds a full flag, a selectable overflow policy and an overflow pulse. It sits between the keypad decoder and the display/command stage.

## Interface
- CHAR_W, 4, bits per character
- DEPTH, 8, character slots (≥2)
- OVF_MODE, 0, 0 = drop oldest on insert when full; 1 = reject insert when full
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- enable  input  1  qualifies insert and bksp
- clr  input  1  synchronous clear, not gated by enable
- bksp  input  1  remove newest character
- is_ctrl  input  1  in_char is a control code, never inserted
- in_char  input  CHAR_W  character to insert
- recall  input  1  restore pre-clear contents (CHARBUF_RECALL_EN only)
- out  output  CHAR_W*DEPTH  buffer; slot 0 = out[CHAR_W-1:0] = newest
- count  output  $clog2(DEPTH+1)  characters held, 0..DEPTH
- is_empty  output  1  count == 0
- is_full  output  1  count == DEPTH
- ovf  output  1  one-cycle pulse: insert hit a full buffer

## Operation
- Per-edge priority: rst > clr > recall > (enable & bksp) > (enable & !is_ctrl) insert > hold.
- Insert:
  - out ← {out[CHAR_W*(DEPTH-1)-1:0], in_char}.
  - count increments, saturating at DEPTH.
- Full-buffer insert, OVF_MODE=0: the oldest slot is shifted out, count stays DEPTH, ovf=1.
- Full-buffer insert, OVF_MODE=1: out and count are unchanged, ovf=1.
- bksp:
  - out ← {CHAR_W'0, out[CHAR_W*DEPTH-1:CHAR_W]}; count decrements.
  - bksp on an empty buffer has no effect and no pulse.
- bksp wins over insert in the same cycle; in_char is ignored that cycle.
- clr: out=0, count=0. ovf is not asserted.
- Unused slots above count always read 0.
- is_empty and is_full are combinational decodes of count. ovf is registered.

## Timing
- Reset values: out=0, count=0, is_empty=1, is_full=0, ovf=0; snapshot register=0.
- Latency: one cycle. Inputs are sampled at edge N; out, count, flags and ovf are valid after edge N.
- ovf is high for exactly the cycle after the offending edge. It is cleared on the next edge unless another overflowing insert occurs.
- Holding enable with a constant in_char inserts one character per clock. No edge detection is done here; the upstream decoder supplies single-cycle strobes.
- rst asserted mid-sequence overrides every other input on that edge.

## Configuration
- CHARBUF_RECALL_EN defined:
  - On every clr edge, the pre-clear out/count are copied to a snapshot register.
  - recall=1 (not gated by enable) loads the snapshot into out/count. The snapshot is retained, so repeated recall is allowed.
  - rst zeroes the snapshot.
- CHARBUF_RECALL_EN undefined:
  - The recall port still exists and is ignored.
  - No snapshot storage is synthesised; behaviour is otherwise identical.

## Structure
- Package charbuf_pkg:
  - ovf_mode_t enum (OVF_DROP_OLDEST=0, OVF_REJECT=1).
  - op_t enum (OP_HOLD, OP_CLR, OP_RECALL, OP_BKSP, OP_INS) for the priority decode.
  - Count-width helper function.
- Sub-module charbuf_snap holds the snapshot register. It is instantiated only under CHARBUF_RECALL_EN.
- The top module holds the shift register, count, flags and ovf.

## Test plan
All scenarios use CHAR_W=4, DEPTH=8.
- Reset/empty: rst=1 for one edge → out=0, count=0, is_empty=1, is_full=0, ovf=0. Set in_char=5, enable=0 → unchanged.
- Zero char counts: enable=1, in_char=0 for one edge → out=0, count=1, is_empty=0.
- Fill and overflow, OVF_MODE=0:
  - Insert 1..8 → out=32'h12345678, is_full=1, ovf=0.
  - Insert 9 → out=32'h23456789, count=8, ovf=1 for one cycle.
- Overflow reject, OVF_MODE=1: full at 32'h12345678, insert 9 → out unchanged, ovf=1.
- Bksp: from 32'h12345678 with enable=1, bksp=1 and in_char=A for one edge → out=32'h01234567, count=7. With enable=0 → unchanged. Eight further bksp edges → out=0, count=0, no ovf.
- Ctrl/clr/recall:
  - is_ctrl=1, enable=1, in_char=5 → no change.
  - At count=3 (out=32'h00000123), clr=1 → out=0, is_empty=1.
  - With CHARBUF_RECALL_EN, recall=1 → out=32'h00000123, count=3.
  - Without the macro, recall=1 → out stays 0.
